multiword_adder_seq: RTL and testbench

MULTIWORD_ADDER_SEQ -- requirements
Module: multiword_adder_seq

---
 rtl/multiword_adder_seq_pkg.sv | 22 ++
 rtl/multiword_adder_seq_add8_slice.sv | 27 ++
 rtl/multiword_adder_seq.sv | 142 ++++++++++++++
 tb/tb_multiword_adder_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/multiword_adder_seq_pkg.sv
// Shared definitions for the sequential multi-word adder.
//   state_t    : FSM states (IDLE, RUN, DONE)
//   DEF_W      : default slice width in bits
//   DEF_WORDS  : default number of slices per operation
//   idx_width(): width of the slice index counter
package multiword_adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_W     = 8;
  localparam int DEF_WORDS = 4;

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/multiword_adder_seq_add8_slice.sv
// One W-bit ripple-carry adder slice.
//   a, b : W-bit addends
//   ci   : carry into bit 0
//   s    : W-bit sum
//   co   : carry out of bit W-1
module add8_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign co = c[W];

endmodule

// File: rtl/multiword_adder_seq.sv
// Sequential N-bit adder/subtractor (N = W*WORDS) built from one W-bit
// slice reused over WORDS consecutive cycles, least significant slice first.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : request a new operation (accepted only while busy=0)
//   sub   : 0 = a+b+cin, 1 = a-b (a+~b+1, cin ignored)
//   a, b  : N-bit operands, cin : carry-in (sampled on the accepting edge)
//   busy  : operation in progress
//   done  : one-cycle pulse when sum/cout/ovf update
//   sum   : registered result, cout : carry-out (NOT borrow for sub)
//   ovf   : registered two's-complement overflow
module multiword_adder_seq
  import multiword_adder_seq_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int WORDS = DEF_WORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sub,
  input  logic [W*WORDS-1:0] a,
  input  logic [W*WORDS-1:0] b,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [W*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf
);

  localparam int N  = W * WORDS;
  localparam int KW = idx_width(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_t        state_reg, state_next;
  logic [KW-1:0] k_reg;
  logic [N-1:0]  a_reg, b_reg, partial_reg, partial_next;
  logic          carry_reg;
  logic [N-1:0]  sum_reg;
  logic          cout_reg, ovf_reg;

  logic [W-1:0]  slice_a, slice_b, slice_s;
  logic          slice_co;
  logic          msb_cin;
  logic          accept;
  logic          last_slice;

  // The operand slice feeding the shared adder is selected by the index.
  assign slice_a    = a_reg[k_reg*W +: W];
  assign slice_b    = b_reg[k_reg*W +: W];
  assign last_slice = (k_reg == K_LAST);

  add8_slice #(.W(W)) u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_reg),
    .s  (slice_s),
    .co (slice_co)
  );

  // Carry into the top bit, recovered from the top bit's sum equation;
  // only meaningful while the last slice is being processed.
  assign msb_cin = slice_a[W-1] ^ slice_b[W-1] ^ slice_s[W-1];

  always_comb begin
    partial_next = partial_reg;
    partial_next[k_reg*W +: W] = slice_s;
  end

  // Next-state and decoded outputs.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg       <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      partial_reg <= '0;
      carry_reg   <= 1'b0;
      sum_reg     <= '0;
      cout_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else if (accept) begin
      // Subtraction is folded into the operands: B inverted, carry forced to 1.
      a_reg       <= a;
      b_reg       <= sub ? ~b : b;
      carry_reg   <= sub ? 1'b1 : cin;
      partial_reg <= '0;
      k_reg       <= '0;
    end else if (state_reg == RUN) begin
      partial_reg <= partial_next;
      carry_reg   <= slice_co;
      k_reg       <= last_slice ? '0 : k_reg + 1'b1;
      if (last_slice) begin
        sum_reg  <= partial_next;
        cout_reg <= slice_co;
        ovf_reg  <= msb_cin ^ slice_co;
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_multiword_adder_seq.sv
module tb_multiword_adder_seq;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, ovf;
  logic [N-1:0] sum;

  multiword_adder_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] s;
    logic         c;
    logic         o;
    int           acc_cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   done_cnt = 0;
  logic [N-1:0] held_sum = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals completion.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_sum"}, sum, e.s);
        check({e.name, "_cout"}, N'(cout), N'(e.c));
        check({e.name, "_ovf"}, N'(ovf), N'(e.o));
        check({e.name, "_latency"}, N'(cyc - e.acc_cyc), N'(4));
        $display("txn %s: sum=%h cout=%0b ovf=%0b at cycle %0d", e.name, sum, cout, ovf, cyc);
      end
    end else if (rst_n && sum !== held_sum) begin
      chk_cnt++;
      $display("FAIL sum_hold: got %h expected %h (cycle %0d)", sum, held_sum, cyc);
    end
    held_sum = sum;
  end

  // Called at posedge+#1; waits (bounded) for busy=0 then presents one request.
  task automatic issue(input string nm, input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic ci, input logic sb_sub,
                       input logic [N-1:0] es, input logic ec, input logic eo);
    exp_t e;
    int n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      chk_cnt++;
      $display("FAIL %s_busy_timeout: got busy=1 expected busy=0", nm);
    end
    a = av; b = bv; cin = ci; sub = sb_sub; start = 1'b1;
    e.s = es; e.c = ec; e.o = eo; e.acc_cyc = cyc + 1; e.name = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = 'x; b = 'x; cin = 1'bx; sub = 1'bx;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int d0;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [N-1:0] bb_a;
    // Reset state
    #12;
    check("rst_sum", sum, '0);
    check("rst_cout", N'(cout), '0);
    check("rst_ovf", N'(ovf), '0);
    check("rst_busy", N'(busy), '0);
    check("rst_done", N'(done), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle without start: no completion in 20 cycles
    base = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("idle_no_done", N'(done_cnt - base), '0);

    // Directed arithmetic vectors
    issue("full_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    drain();
    issue("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    drain();
    issue("sub_borrow", 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    drain();
    issue("cin_carry", 32'h00FF_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h00FF_0100, 1'b0, 1'b0);
    drain();
    issue("sub_small", 32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
    drain();
    issue("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    drain();

    // Back-to-back: start held every cycle, operands change each cycle.
    // Only cycles 0, 5 and 10 fall on accepting edges.
    base = cyc + 1;
    for (int i = 0; i < 15; i++) begin
      bb_a = 32'h0100_0000 + N'(i);
      a = bb_a; b = 32'h00FF_FFFF; cin = 1'b0; sub = 1'b0; start = 1'b1;
      if (i == 0 || i == 5 || i == 10) begin
        exp_t e;
        e.s = (i == 0) ? 32'h01FF_FFFF : (i == 5) ? 32'h0200_0004 : 32'h0200_0009;
        e.c = 1'b0; e.o = 1'b0; e.acc_cyc = base + i;
        e.name = $sformatf("b2b_%0d", i);
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    base = done_cnt;
    drain();
    repeat (6) @(posedge clk);
    #1;
    check("b2b_no_extra_done", N'(done_cnt - base), N'(1));

    // Mid-operation reset: abort two edges after acceptance
    issue("aborted", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_sum", sum, '0);
    check("abort_busy", N'(busy), '0);
    check("abort_done", N'(done), '0);
    base = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue("after_reset", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    drain();
    check("abort_one_done_only", N'(done_cnt - base), N'(1));

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", N'(sb.size()), '0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
